// File: rtl/vga_timing_prog.sv
// -----------------------------------------------------------------------------
// vga_timing_prog
//
// Programmable VGA timing generator. Produces horizontal/vertical pixel
// counters plus sync and blanking strobes from a single pixel clock. A new
// timing set is loaded through a valid/ready config port into a pending
// register set. It is copied into the active set only on the last pixel of a
// frame, so a mode change never produces a torn frame.
//
// Optional feature macro: VGA_TIMING_SYNC_POL_EN
//   defined   : cfg_hsync_pol / cfg_vsync_pol are stored with each config and
//               select the active sync level (reset level: active-high).
//   undefined : polarity ports absent, syncs are always active-high.
//
// Ports
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   cfg_valid/cfg_ready  config handshake (ready while no config is pending)
//   cfg_h_* / cfg_v_*    horizontal / vertical timing fields (CNT_W bits)
//   cfg_hsync_pol/_vsync_pol  active sync levels (macro builds only)
//   cfg_err              one-cycle pulse: offered config was rejected
//   hcount, vcount       current pixel position
//   hsync, vsync         sync strobes for the current position
//   hblnk, vblnk         blanking strobes for the current position
//   frame_start          high while hcount == 0 and vcount == 0
//   mode_switched        one-cycle pulse on the first pixel of a new mode
// -----------------------------------------------------------------------------
module vga_timing_prog #(
  parameter int CNT_W            = 11,
  parameter int RST_H_TOTAL      = 1328,
  parameter int RST_H_BLANK_START = 1024,
  parameter int RST_H_SYNC_START = 1048,
  parameter int RST_H_SYNC_TIME  = 136,
  parameter int RST_V_TOTAL      = 806,
  parameter int RST_V_BLANK_START = 768,
  parameter int RST_V_SYNC_START = 771,
  parameter int RST_V_SYNC_TIME  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_h_total,
  input  logic [CNT_W-1:0] cfg_h_blank_start,
  input  logic [CNT_W-1:0] cfg_h_sync_start,
  input  logic [CNT_W-1:0] cfg_h_sync_time,
  input  logic [CNT_W-1:0] cfg_v_total,
  input  logic [CNT_W-1:0] cfg_v_blank_start,
  input  logic [CNT_W-1:0] cfg_v_sync_start,
  input  logic [CNT_W-1:0] cfg_v_sync_time,
`ifdef VGA_TIMING_SYNC_POL_EN
  input  logic             cfg_hsync_pol,
  input  logic             cfg_vsync_pol,
`endif
  output logic             cfg_err,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic             mode_switched
);

  typedef struct packed {
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_blank_start;
    logic [CNT_W-1:0] h_sync_start;
    logic [CNT_W-1:0] h_sync_time;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_blank_start;
    logic [CNT_W-1:0] v_sync_start;
    logic [CNT_W-1:0] v_sync_time;
`ifdef VGA_TIMING_SYNC_POL_EN
    logic             hsync_pol;
    logic             vsync_pol;
`endif
  } timing_t;

  function automatic timing_t rst_timing();
    timing_t t;
    t.h_total       = CNT_W'(RST_H_TOTAL);
    t.h_blank_start = CNT_W'(RST_H_BLANK_START);
    t.h_sync_start  = CNT_W'(RST_H_SYNC_START);
    t.h_sync_time   = CNT_W'(RST_H_SYNC_TIME);
    t.v_total       = CNT_W'(RST_V_TOTAL);
    t.v_blank_start = CNT_W'(RST_V_BLANK_START);
    t.v_sync_start  = CNT_W'(RST_V_SYNC_START);
    t.v_sync_time   = CNT_W'(RST_V_SYNC_TIME);
`ifdef VGA_TIMING_SYNC_POL_EN
    t.hsync_pol     = 1'b1;
    t.vsync_pol     = 1'b1;
`endif
    return t;
  endfunction

  // One axis is legal when the counter can wrap, blanking starts inside the
  // line/frame, the sync window lies inside blanking and ends by the total.
  // The sync end is summed one bit wider so it cannot wrap.
  function automatic logic axis_ok(input logic [CNT_W-1:0] total,
                                   input logic [CNT_W-1:0] blank_start,
                                   input logic [CNT_W-1:0] sync_start,
                                   input logic [CNT_W-1:0] sync_time);
    logic [CNT_W:0] sync_end;
    sync_end = {1'b0, sync_start} + {1'b0, sync_time};
    return (total >= CNT_W'(2)) &&
           (blank_start <= total) &&
           (sync_start >= blank_start) &&
           (sync_end <= {1'b0, total}) &&
           (sync_time != '0);
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] start,
                                     input logic [CNT_W-1:0] len);
    logic [CNT_W:0] stop;
    stop = {1'b0, start} + {1'b0, len};
    return (pos >= start) && ({1'b0, pos} < stop);
  endfunction

  timing_t act;       // drives the counters and strobes
  timing_t pnd;       // next mode, waiting for the frame boundary
  timing_t cfg_word;
  logic    pend;

  logic h_last, v_last, apply, xfer, cfg_ok;
  logic h_win, v_win;

  // NOTE: every field is assigned unconditionally in always_comb; a path that
  // leaves a variable unassigned would infer a latch.
  always_comb begin
    cfg_word               = '0;
    cfg_word.h_total       = cfg_h_total;
    cfg_word.h_blank_start = cfg_h_blank_start;
    cfg_word.h_sync_start  = cfg_h_sync_start;
    cfg_word.h_sync_time   = cfg_h_sync_time;
    cfg_word.v_total       = cfg_v_total;
    cfg_word.v_blank_start = cfg_v_blank_start;
    cfg_word.v_sync_start  = cfg_v_sync_start;
    cfg_word.v_sync_time   = cfg_v_sync_time;
`ifdef VGA_TIMING_SYNC_POL_EN
    cfg_word.hsync_pol     = cfg_hsync_pol;
    cfg_word.vsync_pol     = cfg_vsync_pol;
`endif
  end

  assign cfg_ready = !pend;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = axis_ok(cfg_h_total, cfg_h_blank_start, cfg_h_sync_start, cfg_h_sync_time) &&
                     axis_ok(cfg_v_total, cfg_v_blank_start, cfg_v_sync_start, cfg_v_sync_time);

  assign h_last = (hcount == (act.h_total - CNT_W'(1)));
  assign v_last = (vcount == (act.v_total - CNT_W'(1)));
  // pend is only set the cycle after a transfer, so a config accepted on the
  // last pixel of a frame waits for the following frame end.
  assign apply  = pend && h_last && v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pending set is reset as well; it is only a handful of flops
      // and keeps the block free of X after reset.
      act           <= rst_timing();
      pnd           <= rst_timing();
      pend          <= 1'b0;
      hcount        <= '0;
      vcount        <= '0;
      cfg_err       <= 1'b0;
      mode_switched <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples
      // values from before this edge.
      cfg_err       <= xfer && !cfg_ok;
      mode_switched <= apply;
      if (apply) begin
        act    <= pnd;
        pend   <= 1'b0;
        hcount <= '0;
        vcount <= '0;
      end else begin
        if (h_last) begin
          hcount <= '0;
          vcount <= v_last ? '0 : vcount + CNT_W'(1);
        end else begin
          hcount <= hcount + CNT_W'(1);
        end
        if (xfer && cfg_ok) begin
          pnd  <= cfg_word;
          pend <= 1'b1;
        end
      end
    end
  end

  assign h_win = in_window(hcount, act.h_sync_start, act.h_sync_time);
  assign v_win = in_window(vcount, act.v_sync_start, act.v_sync_time);

`ifdef VGA_TIMING_SYNC_POL_EN
  assign hsync = h_win ? act.hsync_pol : !act.hsync_pol;
  assign vsync = v_win ? act.vsync_pol : !act.vsync_pol;
`else
  assign hsync = h_win;
  assign vsync = v_win;
`endif

  assign hblnk       = (hcount >= act.h_blank_start);
  assign vblnk       = (vcount >= act.v_blank_start);
  assign frame_start = (hcount == '0) && (vcount == '0);

endmodule

// File: tb/tb_vga_timing_prog.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_prog
//
// Directed bench for vga_timing_prog. The DUT is built with a reduced reset
// mode (line 40 pixels, frame 12 lines = 480 cycles) so full frames and mode
// switches fit in a short run. A small behavioural model tracks the expected
// position, active/pending mode and pulses; the scenario tasks tell it whether
// an offered config should be accepted or rejected.
// -----------------------------------------------------------------------------
module tb_vga_timing_prog;

  localparam int CW = 11;

  typedef struct {
    int ht, hbs, hss, hst;
    int vt, vbs, vss, vst;
    bit hpol, vpol;
  } tcfg_t;

  localparam int V_NONE = 0, V_ACCEPT = 1, V_REJECT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_h_total, cfg_h_blank_start, cfg_h_sync_start, cfg_h_sync_time;
  logic [CW-1:0] cfg_v_total, cfg_v_blank_start, cfg_v_sync_start, cfg_v_sync_time;
  logic          cfg_hsync_pol = 1'b1, cfg_vsync_pol = 1'b1;
  logic          cfg_err;
  logic [CW-1:0] hcount, vcount;
  logic          hsync, vsync, hblnk, vblnk, frame_start, mode_switched;

  vga_timing_prog #(
    .CNT_W(CW),
    .RST_H_TOTAL(40), .RST_H_BLANK_START(32), .RST_H_SYNC_START(34), .RST_H_SYNC_TIME(4),
    .RST_V_TOTAL(12), .RST_V_BLANK_START(10), .RST_V_SYNC_START(10), .RST_V_SYNC_TIME(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_total(cfg_h_total), .cfg_h_blank_start(cfg_h_blank_start),
    .cfg_h_sync_start(cfg_h_sync_start), .cfg_h_sync_time(cfg_h_sync_time),
    .cfg_v_total(cfg_v_total), .cfg_v_blank_start(cfg_v_blank_start),
    .cfg_v_sync_start(cfg_v_sync_start), .cfg_v_sync_time(cfg_v_sync_time),
`ifdef VGA_TIMING_SYNC_POL_EN
    .cfg_hsync_pol(cfg_hsync_pol), .cfg_vsync_pol(cfg_vsync_pol),
`endif
    .cfg_err(cfg_err),
    .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
    .frame_start(frame_start), .mode_switched(mode_switched)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  tcfg_t rst_cfg = '{40, 32, 34, 4, 12, 10, 10, 2, 1'b1, 1'b1};
  tcfg_t ma, mp, drv;
  int    mh, mv;
  bit    mpend, msw, merr;
  int    verdict = V_NONE;
  int    walk_errs = 0;
  string first_bad = "";

  task automatic drive_cfg(input tcfg_t t);
    drv               = t;
    cfg_h_total       = CW'(t.ht);
    cfg_h_blank_start = CW'(t.hbs);
    cfg_h_sync_start  = CW'(t.hss);
    cfg_h_sync_time   = CW'(t.hst);
    cfg_v_total       = CW'(t.vt);
    cfg_v_blank_start = CW'(t.vbs);
    cfg_v_sync_start  = CW'(t.vss);
    cfg_v_sync_time   = CW'(t.vst);
    cfg_hsync_pol     = t.hpol;
    cfg_vsync_pol     = t.vpol;
  endtask

  task automatic model_reset();
    ma = rst_cfg; mp = rst_cfg;
    mh = 0; mv = 0;
    mpend = 1'b0; msw = 1'b0; merr = 1'b0;
  endtask

  // Compare every output against the model at the current sample point, then
  // advance the model and the clock by one cycle.
  task automatic tick();
    bit hw, vw, ehs, evs, bad, apply, xfer;
    hw = (mh >= ma.hss) && (mh < ma.hss + ma.hst);
    vw = (mv >= ma.vss) && (mv < ma.vss + ma.vst);
`ifdef VGA_TIMING_SYNC_POL_EN
    ehs = hw ? ma.hpol : !ma.hpol;
    evs = vw ? ma.vpol : !ma.vpol;
`else
    ehs = hw;
    evs = vw;
`endif
    bad = (hcount !== CW'(mh)) || (vcount !== CW'(mv)) ||
          (hsync !== ehs) || (vsync !== evs) ||
          (hblnk !== (mh >= ma.hbs)) || (vblnk !== (mv >= ma.vbs)) ||
          (frame_start !== (mh == 0 && mv == 0)) ||
          (mode_switched !== msw) || (cfg_err !== merr) || (cfg_ready !== !mpend);
    if (bad) begin
      walk_errs++;
      if (first_bad == "")
        first_bad = $sformatf("got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b ms=%b err=%b rdy=%b, want h=%0d v=%0d hs=%b vs=%b ms=%b err=%b rdy=%b",
                              hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, mode_switched,
                              cfg_err, cfg_ready, mh, mv, ehs, evs, msw, merr, !mpend);
    end
    apply = mpend && (mh == ma.ht - 1) && (mv == ma.vt - 1);
    xfer  = cfg_valid && !mpend;
    merr  = xfer && (verdict == V_REJECT);
    msw   = apply;
    if (apply) begin
      ma = mp; mpend = 1'b0; mh = 0; mv = 0;
    end else begin
      if (mh == ma.ht - 1) begin
        mh = 0;
        mv = (mv == ma.vt - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (xfer && verdict == V_ACCEPT) begin
        mp = drv; mpend = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input tcfg_t t, input int v);
    drive_cfg(t);
    verdict   = v;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    verdict   = V_NONE;
  endtask

  // Runs until the model applies the pending mode (bounded).
  task automatic run_to_switch(input string name);
    int n = 0;
    while (!msw && n < 2000) begin tick(); n++; end
    tests++;
    if (!msw) begin
      fails++;
      $display("FAIL %s: mode switch not reached within %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    drive_cfg(rst_cfg);
    @(posedge clk); #1;
    tests++; if (hcount !== '0) begin fails++; $display("FAIL reset_hcount: got %0d, want 0", hcount); end
    tests++; if (vcount !== '0) begin fails++; $display("FAIL reset_vcount: got %0d, want 0", vcount); end
    tests++; if ({hsync, vsync, hblnk, vblnk} !== 4'b0000) begin fails++; $display("FAIL reset_strobes: got %b, want 0000", {hsync, vsync, hblnk, vblnk}); end
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %b, want 1", cfg_ready); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err: got %b, want 0", cfg_err); end
    tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL reset_frame_start: got %b, want 1", frame_start); end
    tests++; if (mode_switched !== 1'b0) begin fails++; $display("FAIL reset_mode_switched: got %b, want 0", mode_switched); end
    rst_n = 1'b1;
    model_reset();
  endtask

  // Reset mode: hblnk from 32, hsync 34..37, vsync/vblnk from line 10, frame 480.
  task automatic test_default_timing();
    run(31);
    tests++; if (hblnk !== 1'b0) begin fails++; $display("FAIL dflt_hblnk_31: got %b, want 0", hblnk); end
    tick();
    tests++; if (hblnk !== 1'b1) begin fails++; $display("FAIL dflt_hblnk_32: got %b, want 1", hblnk); end
    tick();
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL dflt_hsync_33: got %b, want 0", hsync); end
    tick();
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL dflt_hsync_34: got %b, want 1", hsync); end
    run(3);
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL dflt_hsync_37: got %b, want 1", hsync); end
    tick();
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL dflt_hsync_38: got %b, want 0", hsync); end
    run(361);
    tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL dflt_vsync_line9: got %b, want 0", vsync); end
    tick();
    tests++; if ({vsync, vblnk} !== 2'b11) begin fails++; $display("FAIL dflt_vsync_line10: got %b, want 11", {vsync, vblnk}); end
    run(80);
    // 480 cycles after the previous frame start.
    tests++; if ({frame_start, hcount, vcount} !== {1'b1, CW'(0), CW'(0)}) begin
      fails++; $display("FAIL dflt_frame_period: got fs=%b h=%0d v=%0d, want fs=1 h=0 v=0", frame_start, hcount, vcount);
    end
    tests++; if (walk_errs != 0) begin fails++; $display("FAIL dflt_walk: %0d bad cycles, first %s", walk_errs, first_bad); end
    walk_errs = 0; first_bad = "";
  endtask

  // Mid-frame load of 20/16/17/2 x 8/6/7/1, then a second offer while pending.
  task automatic test_mode_load();
    tcfg_t a1 = '{20, 16, 17, 2, 8, 6, 7, 1, 1'b1, 1'b1};
    tcfg_t b  = '{30, 24, 25, 3, 10, 8, 9, 1, 1'b1, 1'b1};
    run(100);
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL load_ready_before: got %b, want 1", cfg_ready); end
    send(a1, V_ACCEPT);
    tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL load_ready_after: got %b, want 0", cfg_ready); end
    // Second offer while pending: must not be taken.
    drive_cfg(b);
    verdict = V_ACCEPT;
    cfg_valid = 1'b1;
    run(5);
    cfg_valid = 1'b0;
    verdict = V_NONE;
    // Old mode continues: 480 - 106 cycles left in the frame.
    run(374);
    tests++; if ({mode_switched, frame_start, cfg_ready} !== 3'b111) begin
      fails++; $display("FAIL load_apply: got ms/fs/rdy=%b, want 111", {mode_switched, frame_start, cfg_ready});
    end
    tick();
    tests++; if (mode_switched !== 1'b0) begin fails++; $display("FAIL load_ms_pulse: got %b, want 0", mode_switched); end
    run(16);
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL load_hsync_17: got %b, want 1 (first config)", hsync); end
    run(3);
    tests++; if ({hcount, vcount} !== {CW'(0), CW'(1)}) begin
      fails++; $display("FAIL load_line_len: got h=%0d v=%0d, want h=0 v=1", hcount, vcount);
    end
    run(140);
    tests++; if ({frame_start, mode_switched} !== 2'b10) begin
      fails++; $display("FAIL load_frame160: got fs/ms=%b, want 10", {frame_start, mode_switched});
    end
    tests++; if (walk_errs != 0) begin fails++; $display("FAIL load_walk: %0d bad cycles, first %s", walk_errs, first_bad); end
    walk_errs = 0; first_bad = "";
  endtask

  task automatic test_illegal();
    tcfg_t bad_cfg [4];
    bad_cfg[0] = '{40, 32, 34, 10, 12, 10, 10, 2, 1'b1, 1'b1}; // h sync ends past total
    bad_cfg[1] = '{20, 16, 17, 0, 8, 6, 7, 1, 1'b1, 1'b1};     // zero sync time
    bad_cfg[2] = '{20, 16, 17, 2, 1, 0, 0, 1, 1'b1, 1'b1};     // v total < 2
    bad_cfg[3] = '{20, 16, 15, 2, 8, 6, 7, 1, 1'b1, 1'b1};     // sync before blank
    for (int i = 0; i < 4; i++) begin
      send(bad_cfg[i], V_REJECT);
      tests++; if ({cfg_err, cfg_ready} !== 2'b11) begin
        fails++; $display("FAIL illegal_%0d_err: got err/rdy=%b, want 11", i, {cfg_err, cfg_ready});
      end
      tick();
      tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL illegal_%0d_pulse: got %b, want 0", i, cfg_err); end
    end
    run(160);
    tests++; if (walk_errs != 0) begin fails++; $display("FAIL illegal_walk: %0d bad cycles, first %s", walk_errs, first_bad); end
    walk_errs = 0; first_bad = "";
  endtask

  // Sync window ending exactly at the total is legal.
  task automatic test_boundary();
    tcfg_t edge_cfg = '{24, 20, 22, 2, 6, 5, 5, 1, 1'b1, 1'b1};
    send(edge_cfg, V_ACCEPT);
    run_to_switch("boundary_switch");
    run(23);
    tests++; if ({hsync, hblnk} !== 2'b11) begin fails++; $display("FAIL boundary_h23: got hs/hb=%b, want 11", {hsync, hblnk}); end
    tick();
    tests++; if ({hsync, vcount} !== {1'b0, CW'(1)}) begin
      fails++; $display("FAIL boundary_wrap: got hs=%b v=%0d, want hs=0 v=1", hsync, vcount);
    end
    run(144);
    tests++; if (walk_errs != 0) begin fails++; $display("FAIL boundary_walk: %0d bad cycles, first %s", walk_errs, first_bad); end
    walk_errs = 0; first_bad = "";
  endtask

  task automatic test_reset_mid();
    tcfg_t a1 = '{20, 16, 17, 2, 8, 6, 7, 1, 1'b1, 1'b1};
    run(30);
    send(a1, V_ACCEPT);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({hcount, vcount} !== {CW'(0), CW'(0)}) begin
      fails++; $display("FAIL rstmid_count: got h=%0d v=%0d, want 0 0", hcount, vcount);
    end
    tests++; if ({cfg_ready, frame_start, mode_switched, hblnk, vblnk} !== 5'b11000) begin
      fails++; $display("FAIL rstmid_flags: got %b, want 11000", {cfg_ready, frame_start, mode_switched, hblnk, vblnk});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    run(480);
    tests++; if ({frame_start, mode_switched} !== 2'b10) begin
      fails++; $display("FAIL rstmid_no_apply: got fs/ms=%b, want 10", {frame_start, mode_switched});
    end
    tests++; if (walk_errs != 0) begin fails++; $display("FAIL rstmid_walk: %0d bad cycles, first %s", walk_errs, first_bad); end
    walk_errs = 0; first_bad = "";
  endtask

`ifdef VGA_TIMING_SYNC_POL_EN
  task automatic test_polarity();
    tcfg_t neg = '{20, 16, 17, 2, 8, 6, 7, 1, 1'b0, 1'b1};
    send(neg, V_ACCEPT);
    run_to_switch("pol_switch");
    tests++; if (hsync !== 1'b1) begin fails++; $display("FAIL pol_idle: got %b, want 1", hsync); end
    run(17);
    tests++; if (hsync !== 1'b0) begin fails++; $display("FAIL pol_window: got %b, want 0", hsync); end
    run(160);
    tests++; if (walk_errs != 0) begin fails++; $display("FAIL pol_walk: %0d bad cycles, first %s", walk_errs, first_bad); end
    walk_errs = 0; first_bad = "";
  endtask
`endif

  initial begin
    test_reset();
    test_default_timing();
    test_mode_load();
    test_illegal();
    test_boundary();
    test_reset_mid();
`ifdef VGA_TIMING_SYNC_POL_EN
    test_polarity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
